// File: rtl/sample_reader_pkg.sv
// Shared definitions for the sample buffer drain path: state encoding and
// acquisition defaults also used by the capture side.
package sample_reader_pkg;

    localparam int unsigned STATE_SIZE             = 3;
    localparam int unsigned SAMPLE_COUNT_DEFAULT   = 1024;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

    typedef enum logic [STATE_SIZE-1:0] {
        StIdle      = 3'd0,
        StWaitValid = 3'd1,
        StSend      = 3'd2,
        StPulse     = 3'd3,
        StGap       = 3'd4,
        StDone      = 3'd5,
        StError     = 3'd6
    } state_t;

endpackage

// File: rtl/sample_reader_timeout_counter.sv
// Cycle counter for the timed reader states; expires on the last allowed cycle.
module timeout_counter
    import sample_reader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/sample_reader.sv
// Drains the capture buffer one sample at a time onto the TX byte stream,
// pulsing o_next per consumed sample and flagging completion or a stalled buffer.
module sample_reader
    import sample_reader_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned SAMPLE_COUNT   = SAMPLE_COUNT_DEFAULT,
    parameter int unsigned COUNT_SIZE     = 11,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_SIZE-1:0]  i_sample_data,
    input  logic                  i_sample_valid,
    output logic                  o_next,
    output logic [DATA_SIZE-1:0]  o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [COUNT_SIZE-1:0] o_count
);

    state_t                  state, state_next;
    logic [DATA_SIZE-1:0]    tx_data_next;
    logic                    tx_valid_next;
    logic [COUNT_SIZE-1:0]   count_next;
    logic                    timer_clear, timer_enable, timer_expired;

    // The first sample may take arbitrarily long while the buffer fills.
    assign timer_enable = (state == StPulse) || ((state == StWaitValid) && (o_count != '0));
    assign timer_clear  = (state_next != state);

    timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (timer_clear),
        .i_enable (timer_enable),
        .o_expired(timer_expired)
    );

    always_comb begin
        state_next    = state;
        tx_data_next  = o_tx_data;
        tx_valid_next = o_tx_valid;
        count_next    = o_count;
        unique case (state)
            StIdle, StDone: begin
                if (i_start) begin
                    state_next = StWaitValid;
                    count_next = '0;
                end
            end
            StWaitValid: begin
                if (i_sample_valid) begin
                    tx_data_next  = i_sample_data;
                    tx_valid_next = 1'b1;
                    state_next    = StSend;
                end else if (timer_expired) begin
                    state_next = StError;
                end
            end
            StSend: begin
                if (o_tx_valid && i_tx_ready) begin
                    tx_valid_next = 1'b0;
                    count_next    = o_count + 1'b1;
                    state_next    = (count_next == COUNT_SIZE'(SAMPLE_COUNT)) ? StDone : StPulse;
                end
            end
            StPulse: begin
                if (!i_sample_valid) begin
                    state_next = StGap;
                end else if (timer_expired) begin
                    state_next = StError;
                end
            end
            StGap: begin
                state_next = StWaitValid;
            end
            StError: begin
                tx_valid_next = 1'b0;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // Status outputs are registered copies of the state being entered.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= StIdle;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_count    <= '0;
            o_next     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_next;
            o_tx_data  <= tx_data_next;
            o_tx_valid <= tx_valid_next;
            o_count    <= count_next;
            o_next     <= (state_next == StPulse);
            o_busy     <= (state_next inside {StWaitValid, StSend, StPulse, StGap});
            o_done     <= (state_next == StDone);
            o_error    <= (state_next == StError);
        end
    end

endmodule

// File: tb/tb_sample_reader.sv
// Self-checking bench for sample_reader with a behavioural capture-buffer model
// and a monitor that records every accepted byte and o_next rising edge.
module tb_sample_reader;

    localparam int SC = 4;
    localparam int TO = 8;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_sample_data;
    logic        i_sample_valid;
    logic        o_next;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [10:0] o_count;

    int         n_checks;
    int         n_fail;
    logic [7:0] buf_data [SC];
    int         load_gen;
    int         load_delay;
    int         refill_delay;
    bit         load_stall;
    logic [7:0] got_q [$];
    int         next_rises;

    sample_reader #(
        .DATA_SIZE     (8),
        .SAMPLE_COUNT  (SC),
        .COUNT_SIZE    (11),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_sample_data (i_sample_data),
        .i_sample_valid(i_sample_valid),
        .o_next        (o_next),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_count       (o_count)
    );

    always #5 i_clock = ~i_clock;

    // Capture buffer: presents one sample, drops valid on each o_next rising edge,
    // then presents the following sample after a refill delay. Stall mode never drops.
    initial begin
        int  gen_seen;
        int  idx;
        int  wait_cnt;
        bit  prev;
        bit  stall;
        gen_seen = 0; idx = 0; wait_cnt = 0; prev = 1'b0; stall = 1'b0;
        i_sample_valid = 1'b0;
        i_sample_data  = 8'h00;
        forever begin
            @(posedge i_clock); #1;
            if (load_gen != gen_seen) begin
                gen_seen       = load_gen;
                idx            = 0;
                wait_cnt       = load_delay;
                stall          = load_stall;
                i_sample_valid = 1'b0;
                prev           = o_next;
            end else if (gen_seen != 0) begin
                if (o_next && !prev) begin
                    if (!stall) begin
                        i_sample_valid = 1'b0;
                        idx++;
                        wait_cnt = refill_delay;
                    end
                end else if (!i_sample_valid && idx < SC) begin
                    if (wait_cnt == 0) begin
                        i_sample_valid = 1'b1;
                        i_sample_data  = buf_data[idx];
                    end else begin
                        wait_cnt--;
                    end
                end
                prev = o_next;
            end
        end
    end

    // Monitor: a byte seen valid&ready at the negedge transfers on the next posedge.
    initial begin
        bit last_next;
        last_next  = 1'b0;
        next_rises = 0;
        forever begin
            @(negedge i_clock);
            if (o_tx_valid && i_tx_ready && !i_reset) got_q.push_back(o_tx_data);
            if (o_next && !last_next) next_rises++;
            last_next = o_next;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clock); #1;
    endtask

    task automatic pulse_start();
        tick(); i_start = 1'b1;
        tick(); i_start = 1'b0;
    endtask

    task automatic load_buffer(input bit random_data, input int first_delay, input bit stall);
        for (int i = 0; i < SC; i++) begin
            if (random_data) buf_data[i] = 8'($urandom);
            else             buf_data[i] = 8'(8'hA1 + 8'(i * 8'h11));
        end
        load_delay   = first_delay;
        load_stall   = stall;
        refill_delay = $urandom_range(0, 3);
        load_gen++;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clock);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick(); tick();
        @(negedge i_clock);
        n_checks++;
        if ({o_next, o_tx_valid, o_busy, o_done, o_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {o_next, o_tx_valid, o_busy, o_done, o_error});
        end
        n_checks++;
        if (o_tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h want 00", o_tx_data);
        end
        tick(); i_reset = 1'b0;
        @(negedge i_clock);
        n_checks++;
        if (o_count !== 11'd0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: count %0d busy %b want 0 0", o_count, o_busy);
        end
    endtask

    task automatic test_nominal();
        int base, r0;
        bit ok;
        base = got_q.size(); r0 = next_rises;
        i_tx_ready = 1'b1;
        load_buffer(1'b0, 2, 1'b0);
        pulse_start();
        wait_done(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nom_done: got o_done=0 want 1"); end
        n_checks++;
        if (got_q.size() - base !== SC) begin
            n_fail++; $display("FAIL nom_nbytes: got %0d want %0d", got_q.size() - base, SC);
        end
        for (int i = 0; i < SC; i++) begin
            n_checks++;
            if (got_q.size() <= base + i) begin
                n_fail++; $display("FAIL nom_byte%0d: got none want %h", i, buf_data[i]);
            end else if (got_q[base + i] !== buf_data[i]) begin
                n_fail++; $display("FAIL nom_byte%0d: got %h want %h", i, got_q[base + i], buf_data[i]);
            end
        end
        n_checks++;
        if (next_rises - r0 !== SC - 1) begin
            n_fail++; $display("FAIL nom_next_edges: got %0d want %0d", next_rises - r0, SC - 1);
        end
        n_checks++;
        if (o_count !== 11'(SC) || o_busy !== 1'b0 || o_error !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_final: count %0d busy %b err %b want %0d 0 0",
                     o_count, o_busy, o_error, SC);
        end
    endtask

    task automatic test_restart();
        int base;
        bit ok;
        base = got_q.size();
        load_buffer(1'b1, 1, 1'b0);
        pulse_start();
        @(negedge i_clock);
        n_checks++;
        if ({o_done, o_busy} !== 2'b01 || o_count !== 11'd0) begin
            n_fail++;
            $display("FAIL restart_clear: done %b busy %b count %0d want 0 1 0", o_done, o_busy, o_count);
        end
        wait_done(300, ok);
        n_checks++;
        if (!ok || o_count !== 11'(SC)) begin
            n_fail++; $display("FAIL restart_done: done %b count %0d want 1 %0d", ok, o_count, SC);
        end
        for (int i = 0; i < SC; i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base + i] !== buf_data[i]) begin
                n_fail++; $display("FAIL restart_byte%0d: got missing/wrong want %h", i, buf_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int  base, hold_rises;
        bit  ok;
        base = got_q.size();
        i_tx_ready = 1'b1;
        load_buffer(1'b1, 1, 1'b0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (got_q.size() - base >= 1) begin i_tx_ready = 1'b0; ok = 1'b1; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_first: got no transfer want 1"); end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge i_clock);
            if (o_tx_valid) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_second_valid: got o_tx_valid=0 want 1"); end
        hold_rises = next_rises;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({o_tx_valid, o_next, o_error, o_tx_data} !== {1'b1, 1'b0, 1'b0, buf_data[1]}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid %b next %b err %b data %h want 1 0 0 %h",
                         i, o_tx_valid, o_next, o_error, o_tx_data, buf_data[1]);
            end
            @(negedge i_clock);
        end
        n_checks++;
        if (next_rises !== hold_rises) begin
            n_fail++; $display("FAIL bp_no_next: got %0d edges want 0", next_rises - hold_rises);
        end
        tick(); i_tx_ready = 1'b1;
        wait_done(300, ok);
        n_checks++;
        if (!ok || o_count !== 11'(SC) || o_error !== 1'b0) begin
            n_fail++; $display("FAIL bp_done: done %b count %0d err %b want 1 %0d 0", ok, o_count, o_error, SC);
        end
        for (int i = 0; i < SC; i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base + i] !== buf_data[i]) begin
                n_fail++; $display("FAIL bp_byte%0d: got missing/wrong want %h", i, buf_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int base;
        bit ok;
        base = got_q.size();
        i_tx_ready = 1'b1;
        load_buffer(1'b1, 1, 1'b0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (got_q.size() - base >= 1) begin i_tx_ready = 1'b0; ok = 1'b1; end
        end
        for (int i = 0; i < 100 && !o_tx_valid; i++) @(negedge i_clock);
        n_checks++;
        if (o_tx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_send: got valid=0 want 1"); end
        tick(); i_reset = 1'b1;
        @(posedge i_clock); @(negedge i_clock);
        n_checks++;
        if ({o_next, o_tx_valid, o_busy, o_done, o_error, o_tx_data, o_count} !== 24'b0) begin
            n_fail++;
            $display("FAIL rst_mid_zero: next %b valid %b busy %b done %b err %b data %h count %0d want all 0",
                     o_next, o_tx_valid, o_busy, o_done, o_error, o_tx_data, o_count);
        end
        tick(); i_reset = 1'b0; i_tx_ready = 1'b1;
        base = got_q.size();
        load_buffer(1'b1, 2, 1'b0);
        pulse_start();
        @(negedge i_clock);
        n_checks++;
        if (o_count !== 11'd0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_restart: count %0d busy %b want 0 1", o_count, o_busy);
        end
        wait_done(300, ok);
        n_checks++;
        if (!ok || o_count !== 11'(SC) || got_q.size() - base !== SC) begin
            n_fail++;
            $display("FAIL rst_mid_done: done %b count %0d bytes %0d want 1 %0d %0d",
                     ok, o_count, got_q.size() - base, SC, SC);
        end
    endtask

    task automatic test_stall();
        int r0, n;
        bit ok;
        r0 = next_rises;
        i_tx_ready = 1'b1;
        load_buffer(1'b1, 1, 1'b1);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clock);
            if (o_next) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_next: got o_next=0 want 1"); end
        n = 0;
        for (int i = 0; i < 50 && !o_error; i++) begin
            @(negedge i_clock);
            n++;
        end
        n_checks++;
        if (n !== TO || o_error !== 1'b1) begin
            n_fail++; $display("FAIL stall_timeout: got error after %0d cycles want %0d", n, TO);
        end
        n_checks++;
        if ({o_next, o_tx_valid, o_busy} !== 3'b000) begin
            n_fail++; $display("FAIL stall_outputs: next %b valid %b busy %b want 0 0 0", o_next, o_tx_valid, o_busy);
        end
        pulse_start();
        repeat (5) @(negedge i_clock);
        n_checks++;
        if ({o_error, o_busy, o_done, o_next} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_sticky: err %b busy %b done %b next %b want 1 0 0 0", o_error, o_busy, o_done, o_next);
        end
        n_checks++;
        if (next_rises - r0 !== 1) begin
            n_fail++; $display("FAIL stall_edges: got %0d want 1", next_rises - r0);
        end
        tick(); i_reset = 1'b1;
        tick(); i_reset = 1'b0;
    endtask

    task automatic test_late_first();
        int base;
        bit ok;
        base = got_q.size();
        i_tx_ready = 1'b1;
        load_buffer(1'b1, 500, 1'b0);
        pulse_start();
        repeat (300) @(negedge i_clock);
        n_checks++;
        if ({o_error, o_busy, o_tx_valid} !== 3'b010) begin
            n_fail++; $display("FAIL late_waiting: err %b busy %b valid %b want 0 1 0", o_error, o_busy, o_tx_valid);
        end
        wait_done(800, ok);
        n_checks++;
        if (!ok || o_count !== 11'(SC) || o_error !== 1'b0) begin
            n_fail++; $display("FAIL late_done: done %b count %0d err %b want 1 %0d 0", ok, o_count, o_error, SC);
        end
        for (int i = 0; i < SC; i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base + i] !== buf_data[i]) begin
                n_fail++; $display("FAIL late_byte%0d: got missing/wrong want %h", i, buf_data[i]);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        load_gen   = 0;
        load_delay = 0;
        load_stall = 1'b0;
        refill_delay = 0;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_tx_ready = 1'b0;
        test_reset();
        test_nominal();
        test_restart();
        test_backpressure();
        test_reset_mid_drain();
        test_stall();
        test_late_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_reader.md
# sample_reader

Drains a filled sample buffer through its sample-by-sample read handshake and forwards each sample as a byte on a valid/ready stream (UART transmitter side). It sits between the ADC capture buffer (`o_data`/`o_valid` outputs, `i_next` rising-edge input) and the serial TX path. It issues one `o_next` rising edge per consumed sample, counts samples, and flags completion or a stalled buffer.

## Interface
- `DATA_SIZE`, 8, sample/byte width
- `SAMPLE_COUNT`, 1024, samples per acquisition
- `COUNT_SIZE`, 11, width of sample counter (must hold `SAMPLE_COUNT`)
- `TIMEOUT_CYCLES`, 256, max wait for a buffer response before error
- `i_clock`  in  1  clock
- `i_reset`  in  1  reset; synchronous, active-high (clock `i_clock`)
- `i_start`  in  1  level/pulse; starts a drain when in IDLE or DONE
- `i_sample_data`  in  DATA_SIZE  sample from buffer
- `i_sample_valid`  in  1  buffer holding a valid sample
- `o_next`  out  1  request next sample (buffer acts on rising edge)
- `o_tx_data`  out  DATA_SIZE  byte to transmitter
- `o_tx_valid`  out  1  byte available
- `i_tx_ready`  in  1  transmitter accepts byte
- `o_busy`  out  1  drain in progress
- `o_done`  out  1  all samples sent (level)
- `o_error`  out  1  timeout occurred (sticky)
- `o_count`  out  COUNT_SIZE  samples accepted by transmitter

## Operation
- States: IDLE, WAIT_VALID, SEND, PULSE, GAP, DONE, ERROR.
- IDLE: all outputs 0. `i_start`=1 → WAIT_VALID; `o_count` cleared.
- WAIT_VALID: on `i_sample_valid`=1 register `i_sample_data` into `o_tx_data`, `o_tx_valid`←1, → SEND. For the first sample (`o_count`=0), no timeout (buffer may still be filling). Otherwise, after `TIMEOUT_CYCLES` cycles in this state → ERROR.
- SEND: `o_tx_data`/`o_tx_valid` held stable until `o_tx_valid && i_tx_ready` in the same cycle.
  - On transfer: `o_tx_valid`←0 and `o_count`←`o_count`+1.
  - If the new count equals `SAMPLE_COUNT` → DONE; else → PULSE.
  - No timeout in SEND (TX backpressure is legal indefinitely).
- PULSE: `o_next`=1. Leave when `i_sample_valid`=0 is sampled, → GAP. After `TIMEOUT_CYCLES` cycles in PULSE → ERROR.
- GAP: `o_next`=0 for exactly 1 cycle (guarantees a fresh rising edge next time), → WAIT_VALID.
- DONE: `o_done`=1, `o_busy`=0, `o_count` holds final value. `i_start` → WAIT_VALID with count cleared.
- ERROR: `o_error`=1, `o_next`=0, `o_tx_valid`=0, `o_busy`=0. Exit only via `i_reset`; `i_start` ignored.
- `o_busy`=1 in WAIT_VALID, SEND, PULSE, GAP.
- `i_start` outside IDLE/DONE is ignored.
- Changes of `i_sample_valid`/`i_sample_data` during SEND are ignored; the byte is already registered.
- Counter arithmetic is unsigned, COUNT_SIZE wide, and never wraps: DONE is entered at `SAMPLE_COUNT`.

## Timing
- All outputs are registered. Reset: state IDLE, every output 0, timeout counter 0. `i_reset` wins over all other inputs; asserting it mid-drain drops `o_next` and `o_tx_valid` the next cycle.
- Sample latency: `i_sample_valid` high at edge N → `o_tx_valid`=1 and `o_tx_data` valid after edge N.
- TX transfer at edge M → `o_next`=1 after edge M (state PULSE), `o_count` updated after edge M.
- Timeout counter clears on every state entry. It increments each cycle in a timed state. ERROR is entered on the edge where the count reaches `TIMEOUT_CYCLES`-1 with the exit condition still false.
- The last sample produces no `o_next` pulse.

## Structure
- Shared package holds the state encoding localparams, `STATE_SIZE`=3, and the default `SAMPLE_COUNT`/`TIMEOUT_CYCLES` constants, which the capture side shares.
- One sub-module, `timeout_counter`, with inputs clear/enable and output `o_expired`, parameterised by `TIMEOUT_CYCLES`. The FSM, data register and sample counter stay in `sample_reader`.

## Test plan
- Parameter overrides for all scenarios: SAMPLE_COUNT=4, TIMEOUT_CYCLES=8.
- Nominal drain: buffer model returns 0xA1,0xB2,0xC3,0xD4 and `i_tx_ready`=1 → bytes appear in order, exactly 3 `o_next` rising edges, `o_count`=4, `o_done`=1, `o_busy`=0.
- Backpressure: `i_tx_ready`=0 for 20 cycles on the 2nd byte → `o_tx_data`=0xB2 stable with `o_tx_valid`=1 throughout, no `o_next` until acceptance, and no error.
- Stalled buffer: after the 1st `o_next`, the model never drops `i_sample_valid` → `o_error`=1 after 8 cycles in PULSE, `o_next`=0, and a later `i_start` is ignored.
- Late first sample: `i_sample_valid` first asserts 500 cycles after `i_start` → no error, drain completes, `o_count`=4.
- Reset mid-drain: `i_reset` during SEND of sample 2 → the next cycle shows all outputs 0. A subsequent `i_start` drains a full 4 samples with `o_count` starting at 0.
- Restart from DONE: `i_start` in DONE → `o_done`=0, `o_count`=0, and a second 4-sample drain completes.
